// File: rtl/blockade_vram_arbiter.sv
// Slot-based port scheduler for the shared 1Kx8 video RAM.
// Video fetches always win; the CPU fills free port cycles and is stalled via READY.
module blockade_vram_arbiter #(
    parameter int AW             = 10,
    parameter int DW             = 8,
    parameter bit CPU_BLANK_ONLY = 1'b1,
    parameter int MAX_WAIT       = 200
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vblank,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_ready,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          starve
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    owner_t     owner_s;
    owner_t     tag1_r;
    owner_t     tag2_r;
    logic       cpu_elig_s;
    logic       cpu_grant_s;
    logic       cpu_busy_r;
    logic [7:0] wait_r;
    logic [7:0] wait_next_s;

    assign cpu_ready = ~cpu_req | cpu_ack;

    // Port-cycle owner selection and CPU wait-count update
    always_comb begin
        owner_s     = OWN_NONE;
        wait_next_s = wait_r;
        cpu_elig_s  = cpu_req && !cpu_busy_r && !cpu_ack && (!CPU_BLANK_ONLY || vblank);
        cpu_grant_s = cpu_elig_s && !vid_req;
        if (vid_req) begin
            owner_s = OWN_VID;
        end else if (cpu_grant_s) begin
            owner_s = OWN_CPU;
        end else begin
            owner_s = OWN_NONE;
        end
        if (cpu_grant_s) begin
            wait_next_s = 8'd0;
        end else if (cpu_req && !cpu_busy_r && (wait_r != 8'hFF)) begin
            wait_next_s = wait_r + 8'd1;
        end else begin
            wait_next_s = wait_r;
        end
    end

    // RAM port registers; ram_addr holds its value on idle cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr  <= {AW{1'b0}};
            ram_we    <= 1'b0;
            ram_wdata <= {DW{1'b0}};
        end else begin
            if (vid_req) begin
                ram_addr <= vid_addr;
            end else if (cpu_grant_s) begin
                ram_addr <= cpu_addr;
            end
            ram_we <= cpu_grant_s & cpu_we;
            if (cpu_grant_s && cpu_we) begin
                ram_wdata <= cpu_wdata;
            end
        end
    end

    // Owner tags follow each port cycle so returning read data reaches its requester
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag1_r    <= OWN_NONE;
            tag2_r    <= OWN_NONE;
            vid_valid <= 1'b0;
            vid_data  <= {DW{1'b0}};
            cpu_ack   <= 1'b0;
            cpu_rdata <= {DW{1'b0}};
        end else begin
            tag1_r    <= owner_s;
            tag2_r    <= tag1_r;
            vid_valid <= (tag2_r == OWN_VID);
            cpu_ack   <= (tag2_r == OWN_CPU);
            if (tag2_r == OWN_VID) begin
                vid_data <= ram_rdata;
            end
            if (tag2_r == OWN_CPU) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

    // Single outstanding CPU access, wait counter and sticky starvation flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_busy_r <= 1'b0;
            wait_r     <= 8'd0;
            starve     <= 1'b0;
        end else begin
            if (cpu_grant_s) begin
                cpu_busy_r <= 1'b1;
            end else if (cpu_ack) begin
                cpu_busy_r <= 1'b0;
            end
            wait_r <= wait_next_s;
            if (wait_r == MAX_WAIT_C) begin
                starve <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_blockade_vram_arbiter.sv
// Scoreboard bench for blockade_vram_arbiter: instance A is blank-only with a short
// starvation limit, instance B grants the CPU in any free cycle.
module tb_blockade_vram_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       vblank = 1'b0;
    logic       vid_req = 1'b0;
    logic [9:0] vid_addr = 10'd0;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [9:0] cpu_addr = 10'd0;
    logic [7:0] cpu_wdata = 8'd0;

    logic [7:0] vid_data_a, cpu_rdata_a, ram_wdata_a, ram_rdata_a;
    logic       vid_valid_a, cpu_ack_a, cpu_ready_a, ram_we_a, starve_a;
    logic [9:0] ram_addr_a;
    logic [7:0] vid_data_b, cpu_rdata_b, ram_wdata_b, ram_rdata_b;
    logic       vid_valid_b, cpu_ack_b, cpu_ready_b, ram_we_b, starve_b;
    logic [9:0] ram_addr_b;

    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];
    logic [7:0] shadow [1024];

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         chk;
    } exp_t;

    exp_t vq_a[$];
    exp_t cq_a[$];
    exp_t vq_b[$];
    exp_t cq_b[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit mon_a_en = 1'b0;
    bit mon_b_en = 1'b0;

    blockade_vram_arbiter #(.AW(10), .DW(8), .CPU_BLANK_ONLY(1'b1), .MAX_WAIT(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .vblank(vblank),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data_a), .vid_valid(vid_valid_a),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_a), .cpu_ack(cpu_ack_a), .cpu_ready(cpu_ready_a),
        .ram_addr(ram_addr_a), .ram_we(ram_we_a), .ram_wdata(ram_wdata_a),
        .ram_rdata(ram_rdata_a), .starve(starve_a)
    );

    blockade_vram_arbiter #(.AW(10), .DW(8), .CPU_BLANK_ONLY(1'b0), .MAX_WAIT(200)) dut_b (
        .clk(clk), .reset_n(reset_n), .vblank(vblank),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data_b), .vid_valid(vid_valid_b),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b), .cpu_ready(cpu_ready_b),
        .ram_addr(ram_addr_b), .ram_we(ram_we_b), .ram_wdata(ram_wdata_b),
        .ram_rdata(ram_rdata_b), .starve(starve_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous read-first RAM models
    always @(posedge clk) begin
        if (ram_we_a) mem_a[ram_addr_a] <= ram_wdata_a;
        ram_rdata_a <= mem_a[ram_addr_a];
        if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
        ram_rdata_b <= mem_b[ram_addr_b];
    end

    // Scoreboard: every result pulse pops the oldest expectation for its stream
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && mon_a_en && vid_valid_a) begin
            checks++;
            if (vq_a.size() == 0) begin
                failures++;
                $display("FAIL vid_a_unexpected cycle=%0d data=%h", cyc, vid_data_a);
            end else begin
                e = vq_a.pop_front();
                if (e.cyc != cyc || vid_data_a !== e.data) begin
                    failures++;
                    $display("FAIL vid_a got cycle=%0d data=%h expected cycle=%0d data=%h",
                             cyc, vid_data_a, e.cyc, e.data);
                end
            end
        end
        if (reset_n && mon_a_en && cpu_ack_a) begin
            checks++;
            if (cq_a.size() == 0) begin
                failures++;
                $display("FAIL cpu_a_unexpected cycle=%0d data=%h", cyc, cpu_rdata_a);
            end else begin
                e = cq_a.pop_front();
                if (e.cyc != cyc || (e.chk && cpu_rdata_a !== e.data)) begin
                    failures++;
                    $display("FAIL cpu_a got cycle=%0d data=%h expected cycle=%0d data=%h",
                             cyc, cpu_rdata_a, e.cyc, e.data);
                end
            end
        end
        if (reset_n && mon_b_en && vid_valid_b) begin
            checks++;
            if (vq_b.size() == 0) begin
                failures++;
                $display("FAIL vid_b_unexpected cycle=%0d data=%h", cyc, vid_data_b);
            end else begin
                e = vq_b.pop_front();
                if (e.cyc != cyc || vid_data_b !== e.data) begin
                    failures++;
                    $display("FAIL vid_b got cycle=%0d data=%h expected cycle=%0d data=%h",
                             cyc, vid_data_b, e.cyc, e.data);
                end
            end
        end
        if (reset_n && mon_b_en && cpu_ack_b) begin
            checks++;
            if (cq_b.size() == 0) begin
                failures++;
                $display("FAIL cpu_b_unexpected cycle=%0d data=%h", cyc, cpu_rdata_b);
            end else begin
                e = cq_b.pop_front();
                if (e.cyc != cyc || (e.chk && cpu_rdata_b !== e.data)) begin
                    failures++;
                    $display("FAIL cpu_b got cycle=%0d data=%h expected cycle=%0d data=%h",
                             cyc, cpu_rdata_b, e.cyc, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit sel_b, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if ((sel_b ? cpu_ack_b : cpu_ack_a) === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic drain(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (vq_a.size() == 0 && cq_a.size() == 0 && vq_b.size() == 0 && cq_b.size() == 0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if ({vid_data_a, cpu_rdata_a, ram_addr_a, ram_wdata_a, vid_valid_a, cpu_ack_a, ram_we_a, starve_a}
            !== 38'd0 || cpu_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_values got vd=%h rd=%h ra=%h wd=%h v=%b a=%b we=%b st=%b rdy=%b required all zero rdy=1",
                     vid_data_a, cpu_rdata_a, ram_addr_a, ram_wdata_a, vid_valid_a, cpu_ack_a,
                     ram_we_a, starve_a, cpu_ready_a);
        end
        repeat (3) tick();
        #3 reset_n = 1'b1;
        tick();
        vblank = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'h77;
        tick();
        checks++;
        if (ram_we_a !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup_we got=%b required=1", ram_we_a);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (ram_we_a !== 1'b0 || {vid_valid_a, cpu_ack_a, starve_a, ram_addr_a, ram_wdata_a} !== 21'd0) begin
            failures++;
            $display("FAIL reset_async got we=%b v=%b a=%b st=%b ra=%h wd=%h required zero",
                     ram_we_a, vid_valid_a, cpu_ack_a, starve_a, ram_addr_a, ram_wdata_a);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (2) tick();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (cpu_ack_a !== 1'b0 || vid_valid_a !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_ack cycle=%0d got ack=%b valid=%b required 0", i, cpu_ack_a, vid_valid_a);
            end
        end
    endtask

    task automatic test_video_latency();
        int t;
        bit ok;
        mon_a_en = 1'b1;
        t = cyc;
        vid_req = 1'b1; vid_addr = 10'h155;
        vq_a.push_back('{t + 3, shadow[10'h155], 1'b1});
        tick();
        vid_req = 1'b0;
        checks++;
        if (ram_addr_a !== 10'h155 || ram_we_a !== 1'b0) begin
            failures++;
            $display("FAIL vid_port got addr=%h we=%b required addr=155 we=0", ram_addr_a, ram_we_a);
        end
        tick();
        tick();
        tick();
        checks++;
        if (vid_valid_a !== 1'b0) begin
            failures++;
            $display("FAIL vid_single_pulse got=%b required=0", vid_valid_a);
        end
        drain(10, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL vid_latency_timeout got=pending required=empty"); end
    endtask

    task automatic test_write_read();
        int t;
        bit ok;
        vblank = 1'b1;
        t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h2AA; cpu_wdata = 8'h3C;
        cq_a.push_back('{t + 3, 8'h00, 1'b0});
        shadow[10'h2AA] = 8'h3C;
        #1;
        checks++;
        if (cpu_ready_a !== 1'b0) begin
            failures++;
            $display("FAIL wr_ready_low got=%b required=0", cpu_ready_a);
        end
        tick();
        checks++;
        if (ram_we_a !== 1'b1 || ram_addr_a !== 10'h2AA || ram_wdata_a !== 8'h3C) begin
            failures++;
            $display("FAIL wr_port got we=%b addr=%h wd=%h required we=1 addr=2aa wd=3c",
                     ram_we_a, ram_addr_a, ram_wdata_a);
        end
        tick();
        checks++;
        if (ram_we_a !== 1'b0) begin
            failures++;
            $display("FAIL wr_we_one_cycle got=%b required=0", ram_we_a);
        end
        wait_ack(1'b0, 10, ok);
        checks++;
        if (!ok || cpu_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL wr_ack got ack_seen=%b ready=%b required 1 1", ok, cpu_ready_a);
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();
        t = cyc;
        cpu_req = 1'b1; cpu_addr = 10'h2AA;
        cq_a.push_back('{t + 3, shadow[10'h2AA], 1'b1});
        wait_ack(1'b0, 10, ok);
        cpu_req = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL rd_ack_timeout got=none required=ack"); end
        drain(10, ok);
    endtask

    task automatic test_collision();
        int t;
        bit ok;
        vblank = 1'b1;
        tick();
        t = cyc;
        vid_req = 1'b1; vid_addr = 10'h100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
        vq_a.push_back('{t + 3, shadow[10'h100], 1'b1});
        cq_a.push_back('{t + 4, shadow[10'h155], 1'b1});
        tick();
        vid_req = 1'b0;
        checks++;
        if (ram_addr_a !== 10'h100) begin
            failures++;
            $display("FAIL coll_vid_slot got addr=%h required=100", ram_addr_a);
        end
        tick();
        checks++;
        if (ram_addr_a !== 10'h155) begin
            failures++;
            $display("FAIL coll_cpu_slot got addr=%h required=155", ram_addr_a);
        end
        wait_ack(1'b0, 10, ok);
        cpu_req = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL coll_ack_timeout got=none required=ack"); end
        drain(10, ok);
    endtask

    task automatic test_blank_stall();
        int s;
        bit ok;
        vblank = 1'b0;
        tick();
        s = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h2AA;
        cq_a.push_back('{s + 43, shadow[10'h2AA], 1'b1});
        for (int k = 1; k < 40; k++) begin
            tick();
            checks++;
            if (cpu_ready_a !== 1'b0 || cpu_ack_a !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready k=%0d got ready=%b ack=%b required 0 0", k, cpu_ready_a, cpu_ack_a);
            end
            if (k == 5 || k == 39) begin
                checks++;
                if (starve_a !== (k == 39)) begin
                    failures++;
                    $display("FAIL stall_starve k=%0d got=%b required=%b", k, starve_a, (k == 39));
                end
            end
        end
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        checks++;
        if (ram_addr_a !== 10'h2AA) begin
            failures++;
            $display("FAIL stall_grant got addr=%h required=2aa", ram_addr_a);
        end
        wait_ack(1'b0, 10, ok);
        checks++;
        if (!ok || cpu_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL stall_ack got ack_seen=%b ready=%b required 1 1", ok, cpu_ready_a);
        end
        cpu_req = 1'b0;
        drain(10, ok);
    endtask

    task automatic test_video_saturation();
        int t;
        bit ok;
        logic [9:0] a;
        repeat (8) tick();
        mon_a_en = 1'b0;
        mon_b_en = 1'b1;
        vblank = 1'b0;
        t = cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
        cq_b.push_back('{t + 53, shadow[10'h155], 1'b1});
        for (int i = 0; i < 50; i++) begin
            a = 10'(i * 37);
            vid_req = 1'b1; vid_addr = a;
            vq_b.push_back('{cyc + 3, shadow[a], 1'b1});
            tick();
        end
        vid_req = 1'b0;
        wait_ack(1'b1, 10, ok);
        cpu_req = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL sat_ack_timeout got=none required=ack"); end
        drain(10, ok);
        tick();
        t = cyc;
        cpu_req = 1'b1; cpu_addr = 10'h2AA;
        cq_b.push_back('{t + 303, shadow[10'h2AA], 1'b1});
        for (int i = 0; i < 300; i++) begin
            if (i == 200 || i == 255 || i == 299) begin
                checks++;
                if (dut_b.wait_r !== ((i == 200) ? 8'd200 : 8'd255)) begin
                    failures++;
                    $display("FAIL sat_wait i=%0d got=%0d required=%0d", i, dut_b.wait_r,
                             (i == 200) ? 200 : 255);
                end
            end
            a = 10'(i * 11 + 5);
            vid_req = 1'b1; vid_addr = a;
            vq_b.push_back('{cyc + 3, shadow[a], 1'b1});
            tick();
        end
        vid_req = 1'b0;
        checks++;
        if (starve_b !== 1'b1) begin
            failures++;
            $display("FAIL sat_starve got=%b required=1", starve_b);
        end
        wait_ack(1'b1, 10, ok);
        cpu_req = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL sat_long_ack_timeout got=none required=ack"); end
        drain(10, ok);
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'(i * 7 + 3);
            mem_b[i] = 8'(i * 7 + 3);
            shadow[i] = 8'(i * 7 + 3);
        end
        mem_a[10'h155] = 8'hA5;
        mem_b[10'h155] = 8'hA5;
        shadow[10'h155] = 8'hA5;
        test_reset();
        test_video_latency();
        test_write_read();
        test_collision();
        test_blank_stall();
        test_video_saturation();
        drain(10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL scoreboard_leftover got va=%0d ca=%0d vb=%0d cb=%0d required 0",
                     vq_a.size(), cq_a.size(), vq_b.size(), cq_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blockade_vram_arbiter.md
# blockade_vram_arbiter

Arbiter for the single 1K×8 video RAM, shared between the video tile fetch and the 8080 CPU bus. It replaces the discrete READY-stall flip-flop with a registered, slot-based port scheduler. Video fetches always win and complete with fixed latency. CPU accesses are granted in free port cycles, optionally only during vertical blank, and are stalled through an 8080-style READY output. A sticky starvation flag is provided for debug.

## Interface
Parameters:
- AW, 10, RAM address width
- DW, 8, RAM data width
- CPU_BLANK_ONLY, 1, when 1 the CPU is granted only while `vblank` = 1; when 0 it is granted in any free cycle
- MAX_WAIT, 200, CPU wait-cycle count (1–255) that sets `starve`

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset_n  in  1  asynchronous active-low reset
- vblank  in  1  1 = vertical blank active
- vid_req  in  1  one-cycle fetch strobe; may be asserted on any cycle
- vid_addr  in  AW  fetch address, sampled with `vid_req`
- vid_data  out  DW  fetched byte
- vid_valid  out  1  one-cycle pulse; `vid_data` is valid while it is high
- cpu_req  in  1  level request; held with `cpu_we`, `cpu_addr` and `cpu_wdata` stable until `cpu_ack`
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  read data; valid with `cpu_ack`
- cpu_ack  out  1  one-cycle completion pulse
- cpu_ready  out  1  `~cpu_req | cpu_ack` (combinational), drives CPU READY
- ram_addr  out  AW  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  DW  registered RAM write data
- ram_rdata  in  DW  synchronous RAM read data, one cycle after the address
- starve  out  1  sticky flag; set when a CPU wait reaches MAX_WAIT

## Operation
- The RAM port is time-slotted. At each clock edge the arbiter picks the owner of the next port cycle:
  - video, if `vid_req` is 1;
  - otherwise the CPU, if it is eligible;
  - otherwise no owner: `ram_we` = 0 and `ram_addr` holds its last value.
- CPU eligibility requires all of the following:
  - `cpu_req` = 1;
  - no CPU access already in flight;
  - the current cycle is not the `cpu_ack` cycle;
  - `CPU_BLANK_ONLY` = 0 or `vblank` = 1.
- The CPU in-flight flag is set at grant and cleared when `cpu_ack` is issued. Only one CPU access is outstanding at a time.
- A video grant drives `ram_addr = vid_addr` with `ram_we` = 0. Video fetches may be back-to-back on every cycle.
- A CPU grant drives `ram_addr = cpu_addr` and `ram_we = cpu_we`; `ram_wdata = cpu_wdata` when writing.
- A 2-bit owner tag pipeline (NONE/VID/CPU) tracks each port cycle so returning `ram_rdata` is routed to the right requester.
- Wait counter (8 bits):
  - increments, saturating at 255, on each cycle where `cpu_req` = 1, no CPU access is in flight, and no grant occurs;
  - clears on grant;
  - `starve` is set when the counter equals MAX_WAIT and is cleared only by reset.
- `vblank` is sampled only at the decision edge. A CPU access granted on the last vblank cycle completes normally.

## Timing
- Reset values: `vid_data`, `cpu_rdata`, `ram_addr` and `ram_wdata` = 0; `vid_valid`, `cpu_ack`, `ram_we` and `starve` = 0; owner tags = NONE; wait counter = 0.
- Reset is asynchronous and may arrive mid-operation. In-flight accesses are dropped with no `vid_valid` or `cpu_ack`, and `ram_we` is forced to 0 immediately.
- Cycle numbering: a request first sampled at the end of cycle T has:
  - its port cycle in T+1;
  - `ram_rdata` available in T+2;
  - its result registered at the end of T+2 and presented in T+3.
- Video latency is fixed at 3 cycles: `vid_valid` is high in T+3 for a `vid_req` in T, regardless of CPU activity.
- CPU, no contention: `cpu_ack` is high in T+3 for both reads and writes. For a write, `ram_we` is high only in T+1.
- CPU losing a port cycle to video is delayed one cycle per video grant.
- The earliest next CPU grant is the cycle after `cpu_ack`. If `cpu_req` stays high in that cycle, it is treated as a new request.
- `cpu_ready` is low from the first `cpu_req` cycle through the cycle before `cpu_ack`.

## Test plan
- Reset: assert `reset_n` = 0 asynchronously mid-write (while `ram_we` = 1) → `ram_we` drops with no clock edge; every output is at its reset value; no `cpu_ack` follows the release of reset.
- Video latency: RAM model [0x155] = 0xA5; `vid_req` with `vid_addr` = 0x155 in cycle 10 → `ram_addr` = 0x155 in cycle 11; `vid_valid` = 1 and `vid_data` = 0xA5 in cycle 13 only.
- CPU write then read in vblank: write 0x3C to 0x2AA → `ram_we` = 1 for one cycle; `cpu_ack` 3 cycles after the request. Read of 0x2AA → `cpu_rdata` = 0x3C with `cpu_ack`.
- Collision: `vid_req` and `cpu_req` both asserted in cycle T during vblank → video port cycle T+1, CPU port cycle T+2; `vid_valid` in T+3, `cpu_ack` in T+4.
- Blank-only stall: CPU_BLANK_ONLY = 1, MAX_WAIT = 16; `cpu_req` asserted 40 cycles before `vblank` rises → `cpu_ready` stays low; `starve` = 1 after 16 wait cycles; the grant occurs on the first cycle with `vblank` sampled high; `cpu_ack` 3 cycles later.
- Video saturation: `vid_req` high for 50 cycles with CPU_BLANK_ONLY = 0 → 50 consecutive `vid_valid` pulses with correct data; the CPU is granted the first free cycle; the wait counter saturates at 255 and does not wrap during a longer run.
